instr_issue_queue: RTL and testbench

INSTR_ISSUE_QUEUE -- requirements
Module: instr_issue_queue

---
 rtl/instr_issue_queue.sv | 136 +++++++++++++
 tb/tb_instr_issue_queue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_queue.sv
// Out-of-order issue queue: tag-based wakeup, oldest-ready select, age-based squash.
// Each entry holds the renamed source tags and their ready bits, the age count and the payload.
module instr_issue_queue #(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 96
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [TAG_W-1:0]             enq_rs_phys,
  input  logic [TAG_W-1:0]             enq_rt_phys,
  input  logic                         enq_rs_rdy,
  input  logic                         enq_rt_rdy,
  input  logic [31:0]                  enq_count,
  input  logic [PAYLOAD_W-1:0]         enq_payload,
  input  logic                         wb_valid,
  input  logic [TAG_W-1:0]             wb_tag,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [TAG_W-1:0]             issue_rs_phys,
  output logic [TAG_W-1:0]             issue_rt_phys,
  output logic [31:0]                  issue_count,
  output logic [PAYLOAD_W-1:0]         issue_payload,
  input  logic                         flush,
  input  logic [31:0]                  flush_count,
  input  logic                         flush_all,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]     valid;
  logic [DEPTH-1:0]     rs_rdy;
  logic [DEPTH-1:0]     rt_rdy;
  logic [TAG_W-1:0]     rs_tag  [DEPTH];
  logic [TAG_W-1:0]     rt_tag  [DEPTH];
  logic [31:0]          count   [DEPTH];
  logic [PAYLOAD_W-1:0] payload [DEPTH];

  logic [DEPTH-1:0] valid_next;
  logic [OCC_W-1:0] occ_next;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] free_idx;
  logic             sel_found;
  logic             any_flush;
  logic             enq_fire;
  logic             issue_fire;

  // Wrap-safe age compare: a is older than b when (a - b) is negative.
  function automatic logic is_older(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    return d[31];
  endfunction

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && rs_rdy[i] && rt_rdy[i]) begin
        if (!sel_found || is_older(count[i], count[sel_idx])) begin
          sel_found = 1'b1;
          sel_idx   = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid[i]) free_idx = IDX_W'(i);
    end
  end

  assign any_flush   = flush | flush_all;
  assign enq_ready   = (occupancy < OCC_W'(DEPTH));
  assign issue_valid = sel_found && !any_flush;
  assign enq_fire    = enq_valid && enq_ready && !any_flush;
  assign issue_fire  = issue_valid && issue_ready;

  assign issue_rs_phys = issue_valid ? rs_tag[sel_idx]  : '0;
  assign issue_rt_phys = issue_valid ? rt_tag[sel_idx]  : '0;
  assign issue_count   = issue_valid ? count[sel_idx]   : '0;
  assign issue_payload = issue_valid ? payload[sel_idx] : '0;

  always_comb begin
    valid_next = valid;
    if (flush_all) begin
      valid_next = '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ($signed(count[i] - flush_count) > 0) valid_next[i] = 1'b0;
      end
    end else begin
      // The free slot is invalid and the selected slot is valid, so they never collide.
      if (issue_fire) valid_next[sel_idx]  = 1'b0;
      if (enq_fire)   valid_next[free_idx] = 1'b1;
    end
  end

  always_comb begin
    occ_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_next = occ_next + OCC_W'(valid_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= '0;
      rs_rdy    <= '0;
      rt_rdy    <= '0;
      occupancy <= '0;
    end else begin
      valid     <= valid_next;
      occupancy <= occ_next;
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_valid && valid[i] && (rs_tag[i] == wb_tag)) rs_rdy[i] <= 1'b1;
        if (wb_valid && valid[i] && (rt_tag[i] == wb_tag)) rt_rdy[i] <= 1'b1;
      end
      if (enq_fire) begin
        rs_tag[free_idx]  <= enq_rs_phys;
        rt_tag[free_idx]  <= enq_rt_phys;
        rs_rdy[free_idx]  <= enq_rs_rdy | (wb_valid && (wb_tag == enq_rs_phys));
        rt_rdy[free_idx]  <= enq_rt_rdy | (wb_valid && (wb_tag == enq_rt_phys));
        count[free_idx]   <= enq_count;
        payload[free_idx] <= enq_payload;
      end
    end
  end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed bench for instr_issue_queue: fill/full, wakeup, bypass, wrap-safe age,
// partial and full flush, and reset overriding everything.
module tb_instr_issue_queue;

  localparam int DEPTH     = 8;
  localparam int TAG_W     = 6;
  localparam int PAYLOAD_W = 96;

  logic                 clk;
  logic                 rst;
  logic                 enq_valid;
  logic                 enq_ready;
  logic [TAG_W-1:0]     enq_rs_phys;
  logic [TAG_W-1:0]     enq_rt_phys;
  logic                 enq_rs_rdy;
  logic                 enq_rt_rdy;
  logic [31:0]          enq_count;
  logic [PAYLOAD_W-1:0] enq_payload;
  logic                 wb_valid;
  logic [TAG_W-1:0]     wb_tag;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [TAG_W-1:0]     issue_rs_phys;
  logic [TAG_W-1:0]     issue_rt_phys;
  logic [31:0]          issue_count;
  logic [PAYLOAD_W-1:0] issue_payload;
  logic                 flush;
  logic [31:0]          flush_count;
  logic                 flush_all;
  logic [3:0]           occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  instr_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_rs_phys(enq_rs_phys), .enq_rt_phys(enq_rt_phys),
    .enq_rs_rdy(enq_rs_rdy), .enq_rt_rdy(enq_rt_rdy),
    .enq_count(enq_count), .enq_payload(enq_payload),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs_phys(issue_rs_phys), .issue_rt_phys(issue_rt_phys),
    .issue_count(issue_count), .issue_payload(issue_payload),
    .flush(flush), .flush_count(flush_count), .flush_all(flush_all),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns after that.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PAYLOAD_W-1:0] pl(input logic [31:0] c);
    return {c, ~c, c ^ 32'h5A5A_A5A5};
  endfunction

  task automatic drive_enq(input logic [31:0] c, input logic [TAG_W-1:0] rs, input logic rsr,
                           input logic [TAG_W-1:0] rt, input logic rtr);
    enq_valid   = 1'b1;
    enq_count   = c;
    enq_rs_phys = rs;
    enq_rs_rdy  = rsr;
    enq_rt_phys = rt;
    enq_rt_rdy  = rtr;
    enq_payload = pl(c);
  endtask

  task automatic enq(input logic [31:0] c, input logic [TAG_W-1:0] rs, input logic rsr,
                     input logic [TAG_W-1:0] rt, input logic rtr);
    drive_enq(c, rs, rsr, rt, rtr);
    step();
    enq_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  logic [31:0] wrap_order [4];

  initial begin
    rst = 1'b1; enq_valid = 1'b0; enq_rs_phys = '0; enq_rt_phys = '0;
    enq_rs_rdy = 1'b0; enq_rt_rdy = 1'b0; enq_count = '0; enq_payload = '0;
    wb_valid = 1'b0; wb_tag = '0; issue_ready = 1'b0;
    flush = 1'b0; flush_count = '0; flush_all = 1'b0;
    step();
    do_reset();
    check("rst_occ", occupancy, 0);
    check("rst_enq_ready", enq_ready, 1);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_issue_count_zero", issue_count, 0);

    // Fill with counts 0..7, then a 9th offer must be ignored.
    for (int i = 0; i < 8; i++) enq(i, 6'(i), 1'b1, 6'(i + 8), 1'b1);
    #1;
    check("full_occ", occupancy, 8);
    check("full_enq_ready", enq_ready, 0);
    check("full_oldest", issue_count, 0);
    enq(99, 6'd1, 1'b1, 6'd2, 1'b1);
    #1;
    check("ninth_ignored_occ", occupancy, 8);
    issue_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", issue_valid, 1);
      check("drain_count", issue_count, i);
      check("drain_rt_tag", issue_rt_phys, i + 8);
      step();
    end
    issue_ready = 1'b0;
    #1;
    check("drain_empty_occ", occupancy, 0);
    check("drain_empty_valid", issue_valid, 0);

    // Not-ready source waits for its writeback; a younger ready entry goes first.
    enq(5, 6'd40, 1'b0, 6'd3, 1'b1);
    enq(6, 6'd4, 1'b1, 6'd5, 1'b1);
    #1;
    check("wake_first", issue_count, 6);
    check("wake_payload", issue_payload, pl(6));
    issue_ready = 1'b1;
    step();
    check("wake_blocked", issue_valid, 0);
    wb_valid = 1'b1; wb_tag = 6'd40;
    #1;
    check("wake_not_same_cycle", issue_valid, 0);
    step();
    wb_valid = 1'b0;
    #1;
    check("wake_valid", issue_valid, 1);
    check("wake_count", issue_count, 5);
    check("wake_rs_tag", issue_rs_phys, 40);
    step();
    issue_ready = 1'b0;
    check("wake_empty", occupancy, 0);

    // Writeback bypass at enqueue.
    drive_enq(20, 6'd33, 1'b0, 6'd7, 1'b1);
    wb_valid = 1'b1; wb_tag = 6'd33;
    step();
    enq_valid = 1'b0; wb_valid = 1'b0;
    #1;
    check("bypass_valid", issue_valid, 1);
    check("bypass_count", issue_count, 20);

    // Same-cycle issue and enqueue both complete.
    issue_ready = 1'b1;
    drive_enq(21, 6'd8, 1'b1, 6'd9, 1'b1);
    #1;
    check("same_cycle_issue", issue_count, 20);
    step();
    enq_valid = 1'b0; issue_ready = 1'b0;
    #1;
    check("same_cycle_occ", occupancy, 1);
    check("same_cycle_next", issue_count, 21);
    do_reset();

    // Wrap-safe ordering; enqueued youngest-first so slot order disagrees with age.
    enq(32'h1, 6'd1, 1'b1, 6'd1, 1'b1);
    enq(32'h0, 6'd1, 1'b1, 6'd1, 1'b1);
    enq(32'hFFFF_FFFF, 6'd1, 1'b1, 6'd1, 1'b1);
    enq(32'hFFFF_FFFE, 6'd1, 1'b1, 6'd1, 1'b1);
    wrap_order[0] = 32'hFFFF_FFFE; wrap_order[1] = 32'hFFFF_FFFF;
    wrap_order[2] = 32'h0;         wrap_order[3] = 32'h1;
    issue_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("wrap_order", issue_count, wrap_order[i]);
      step();
    end
    issue_ready = 1'b0;
    check("wrap_empty", occupancy, 0);

    // Partial flush keeps the branch and older; enqueue and issue blocked that cycle.
    for (int i = 10; i <= 14; i++) enq(i, 6'd2, 1'b1, 6'd3, 1'b1);
    flush = 1'b1; flush_count = 11; issue_ready = 1'b1;
    drive_enq(50, 6'd2, 1'b1, 6'd3, 1'b1);
    #1;
    check("flush_issue_blocked", issue_valid, 0);
    step();
    flush = 1'b0; enq_valid = 1'b0; issue_ready = 1'b0;
    #1;
    check("flush_occ", occupancy, 2);
    check("flush_oldest", issue_count, 10);
    issue_ready = 1'b1;
    step();
    check("flush_second", issue_count, 11);
    step();
    issue_ready = 1'b0;
    check("flush_drained", occupancy, 0);

    // Wakeup still applies to survivors during flush_all-free flush; then flush_all.
    enq(60, 6'd44, 1'b0, 6'd3, 1'b1);
    enq(61, 6'd2, 1'b1, 6'd3, 1'b1);
    flush = 1'b1; flush_count = 60; wb_valid = 1'b1; wb_tag = 6'd44;
    step();
    flush = 1'b0; wb_valid = 1'b0;
    #1;
    check("flush_wake_occ", occupancy, 1);
    check("flush_wake_count", issue_count, 60);
    enq(62, 6'd2, 1'b1, 6'd3, 1'b1);
    flush_all = 1'b1;
    step();
    flush_all = 1'b0;
    #1;
    check("flush_all_occ", occupancy, 0);
    check("flush_all_valid", issue_valid, 0);

    // Reset overrides flush_all, enqueue and issue in the same cycle.
    for (int i = 30; i < 34; i++) enq(i, 6'd2, 1'b1, 6'd3, 1'b1);
    rst = 1'b1; flush_all = 1'b1; issue_ready = 1'b1;
    drive_enq(34, 6'd2, 1'b1, 6'd3, 1'b1);
    step();
    rst = 1'b0; flush_all = 1'b0; enq_valid = 1'b0; issue_ready = 1'b0;
    #1;
    check("rst_override_occ", occupancy, 0);
    check("rst_override_valid", issue_valid, 0);
    check("rst_override_ready", enq_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
